// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_PC     = 32'h0000_4180;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam int          PAYLOAD_IW = 32;
    localparam logic [PAYLOAD_IW-1:0] NOP = '0;

    // Default-width payload bundle for stages that carry a 32-bit instruction.
    typedef struct packed {
        logic [PAYLOAD_IW-1:0] instr;
        logic [31:0]           pc;
        logic [4:0]            exc;
        logic                  bd;
    } pipe_payload_t;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One pipeline entry: payload register plus valid bit, with load / clear / redirect controls.
module stage_entry
    import pipe_pkg::*;
#(
    parameter int          IW      = 32,
    parameter logic [31:0] PC_INIT = pipe_pkg::PC_RESET
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    input  logic [IW-1:0] instr_i,
    input  logic [31:0]   pc_i,
    input  logic [4:0]    exc_i,
    input  logic          bd_i,
    output logic          valid_o,
    output logic [IW-1:0] instr_o,
    output logic [31:0]   pc_o,
    output logic [4:0]    exc_o,
    output logic          bd_o
);

    logic          valid_q, valid_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [31:0]   pc_q, pc_d;
    logic [4:0]    exc_q, exc_d;
    logic          bd_q, bd_d;

    // Clearing zeroes the payload but keeps the PC, so an empty entry reads as a nop bubble.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (redirect_i || clear_i) begin
            valid_d = 1'b0;
            instr_d = '0;
            exc_d   = EXC_NONE;
            bd_d    = 1'b0;
            if (redirect_i) begin
                pc_d = redirect_pc_i;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
            exc_d   = exc_i;
            bd_d    = bd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= PC_INIT;
            exc_q   <= EXC_NONE;
            bd_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign exc_o   = exc_q;
    assign bd_o    = bd_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a one-entry skid buffer, flush and exception redirect.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          IW       = 32,
    parameter logic [31:0] PC_RESET = pipe_pkg::PC_RESET,
    parameter logic [31:0] EXC_PC   = pipe_pkg::EXC_PC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [IW-1:0] up_instr,
    input  logic [31:0]   up_pc,
    input  logic [4:0]    up_exc,
    input  logic          up_bd,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [IW-1:0] dn_instr,
    output logic [31:0]   dn_pc,
    output logic [4:0]    dn_exc,
    output logic          dn_bd,
    input  logic          flush,
    input  logic          req,
    output logic [1:0]    occupancy
);

    logic          main_valid, skid_valid;
    logic [IW-1:0] skid_instr;
    logic [31:0]   skid_pc;
    logic [4:0]    skid_exc;
    logic          skid_bd;

    logic up_xfer, kill, main_free;
    logic main_load, main_clear, main_redirect;
    logic skid_load, skid_clear;
    logic [IW-1:0] main_src_instr;
    logic [31:0]   main_src_pc;
    logic [4:0]    main_src_exc;
    logic          main_src_bd;

    // up_ready comes straight from the skid valid flop, breaking the dn_ready -> up_ready path.
    assign up_ready  = !skid_valid;
    assign up_xfer   = up_valid && !skid_valid;
    assign kill      = flush || req;
    assign main_free = !main_valid || dn_ready;

    always_comb begin
        main_redirect = req;
        main_clear    = 1'b0;
        main_load     = 1'b0;
        skid_clear    = 1'b0;
        skid_load     = 1'b0;
        if (kill) begin
            main_clear = !req;
            skid_clear = 1'b1;
        end else if (main_free) begin
            main_load  = skid_valid || up_xfer;
            main_clear = !(skid_valid || up_xfer);
            skid_clear = skid_valid;
        end else begin
            skid_load  = up_xfer;
        end
    end

    // The skid entry is always older than anything arriving from upstream.
    always_comb begin
        if (skid_valid) begin
            main_src_instr = skid_instr;
            main_src_pc    = skid_pc;
            main_src_exc   = skid_exc;
            main_src_bd    = skid_bd;
        end else begin
            main_src_instr = up_instr;
            main_src_pc    = up_pc;
            main_src_exc   = up_exc;
            main_src_bd    = up_bd;
        end
    end

    stage_entry #(.IW(IW), .PC_INIT(PC_RESET)) u_main (
        .clk           (clk),
        .rst_n         (reset),
        .load_i        (main_load),
        .clear_i       (main_clear),
        .redirect_i    (main_redirect),
        .redirect_pc_i (EXC_PC),
        .instr_i       (main_src_instr),
        .pc_i          (main_src_pc),
        .exc_i         (main_src_exc),
        .bd_i          (main_src_bd),
        .valid_o       (main_valid),
        .instr_o       (dn_instr),
        .pc_o          (dn_pc),
        .exc_o         (dn_exc),
        .bd_o          (dn_bd)
    );

    stage_entry #(.IW(IW), .PC_INIT(PC_RESET)) u_skid (
        .clk           (clk),
        .rst_n         (reset),
        .load_i        (skid_load),
        .clear_i       (skid_clear),
        .redirect_i    (1'b0),
        .redirect_pc_i (EXC_PC),
        .instr_i       (up_instr),
        .pc_i          (up_pc),
        .exc_i         (up_exc),
        .bd_i          (up_bd),
        .valid_o       (skid_valid),
        .instr_o       (skid_instr),
        .pc_o          (skid_pc),
        .exc_o         (skid_exc),
        .bd_o          (skid_bd)
    );

    assign dn_valid  = main_valid;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted entries are queued and compared as they leave.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        up_valid, up_ready;
    logic [31:0] up_instr, up_pc;
    logic [4:0]  up_exc;
    logic        up_bd;
    logic        dn_valid, dn_ready;
    logic [31:0] dn_instr, dn_pc;
    logic [4:0]  dn_exc;
    logic        dn_bd;
    logic        flush, req;
    logic [1:0]  occupancy;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.IW(32), .PC_RESET(32'h0000_3000), .EXC_PC(32'h0000_4180)) dut (
        .clk       (clk),
        .reset     (reset),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_instr  (up_instr),
        .up_pc     (up_pc),
        .up_exc    (up_exc),
        .up_bd     (up_bd),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_instr  (dn_instr),
        .dn_pc     (dn_pc),
        .dn_exc    (dn_exc),
        .dn_bd     (dn_bd),
        .flush     (flush),
        .req       (req),
        .occupancy (occupancy)
    );

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.instr = {pc[15:0] ^ 16'hA5C3, ~pc[15:0]};
        e.pc    = pc;
        e.exc   = pc[6:2];
        e.bd    = pc[3];
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        ent_t e;
        e        = mk(pc);
        up_valid = v;
        up_instr = e.instr;
        up_pc    = e.pc;
        up_exc   = e.exc;
        up_bd    = e.bd;
    endtask

    // Called 1 time unit after a rising edge with inputs already set; advances one cycle.
    task automatic tick();
        logic upx, dnx, kill;
        ent_t got, want, upe;
        upx  = up_valid && up_ready;
        dnx  = dn_valid && dn_ready;
        kill = flush || req;
        got  = {dn_instr, dn_pc, dn_exc, dn_bd};
        upe  = {up_instr, up_pc, up_exc, up_bd};
        if (dnx) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got entry pc=%h, required none", dn_pc);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL sb_data: got %h, required %h", got, want);
                end
            end
        end
        if (upx && !kill) exp_q.push_back(upe);
        if (kill) exp_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (occupancy !== 2'(exp_q.size())) begin
            errors++;
            $display("FAIL occupancy: got %0d, required %0d", occupancy, exp_q.size());
        end
        checks++;
        if (up_ready !== ((exp_q.size() < 2) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL up_ready: got %b, required %b", up_ready, exp_q.size() < 2);
        end
        checks++;
        if (dn_valid !== ((exp_q.size() > 0) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL dn_valid: got %b, required %b", dn_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            checks++;
            if ({dn_instr, dn_pc, dn_exc, dn_bd} !== exp_q[0]) begin
                errors++;
                $display("FAIL head: got %h, required %h", {dn_instr, dn_pc, dn_exc, dn_bd}, exp_q[0]);
            end
        end else begin
            checks++;
            if (dn_instr !== 32'h0 || dn_exc !== 5'h0 || dn_bd !== 1'b0) begin
                errors++;
                $display("FAIL bubble: got instr=%h exc=%h bd=%b, required 0/0/0", dn_instr, dn_exc, dn_bd);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; req = 1'b0; dn_ready = 1'b0;
        drive(1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dn_valid !== 1'b0 || dn_pc !== 32'h3000 || dn_instr !== 32'h0 || dn_exc !== 5'h0 || dn_bd !== 1'b0
            || up_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset: got v=%b pc=%h instr=%h exc=%h bd=%b rdy=%b occ=%0d, required 0/3000/0/0/0/1/0",
                     dn_valid, dn_pc, dn_instr, dn_exc, dn_bd, up_ready, occupancy);
        end
        reset = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic test_pass_through();
        logic [31:0] pcs [3];
        pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
        dn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i]);
            tick();
            checks++;
            if (dn_valid !== 1'b1 || dn_pc !== pcs[i]) begin
                errors++;
                $display("FAIL pass_through: got v=%b pc=%h, required 1/%h", dn_valid, dn_pc, pcs[i]);
            end
        end
        drive(1'b0, 32'h0);
        tick();
    endtask

    task automatic test_back_pressure();
        dn_ready = 1'b0;
        drive(1'b1, 32'h3000); tick();
        drive(1'b1, 32'h3004); tick();
        checks++;
        if (occupancy !== 2'd2 || up_ready !== 1'b0 || dn_pc !== 32'h3000) begin
            errors++;
            $display("FAIL bp_full: got occ=%0d rdy=%b pc=%h, required 2/0/3000", occupancy, up_ready, dn_pc);
        end
        drive(1'b1, 32'h3008); tick();
        checks++;
        if (dn_pc !== 32'h3000 || occupancy !== 2'd2) begin
            errors++;
            $display("FAIL bp_hold: got pc=%h occ=%0d, required 3000/2", dn_pc, occupancy);
        end
        drive(1'b0, 32'h0);
        dn_ready = 1'b1;
        tick();
        checks++;
        if (dn_pc !== 32'h3004 || occupancy !== 2'd1 || up_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got pc=%h occ=%0d rdy=%b, required 3004/1/1", dn_pc, occupancy, up_ready);
        end
        tick();
    endtask

    task automatic test_flush_full();
        dn_ready = 1'b0;
        drive(1'b1, 32'h3010); tick();
        drive(1'b1, 32'h3014); tick();
        drive(1'b0, 32'h0);
        flush = 1'b1; dn_ready = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (dn_valid !== 1'b0 || dn_instr !== 32'h0 || dn_pc !== 32'h3010 || occupancy !== 2'd0 || up_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got v=%b instr=%h pc=%h occ=%0d rdy=%b, required 0/0/3010/0/1",
                     dn_valid, dn_instr, dn_pc, occupancy, up_ready);
        end
    endtask

    task automatic test_exception();
        dn_ready = 1'b0;
        drive(1'b1, 32'h3020); tick();
        req = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h3024);
        tick();
        req = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0);
        checks++;
        if (dn_valid !== 1'b0 || dn_pc !== 32'h4180 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL exception: got v=%b pc=%h occ=%0d, required 0/4180/0", dn_valid, dn_pc, occupancy);
        end
        dn_ready = 1'b1;
        tick();
        checks++;
        if (dn_valid !== 1'b0 || dn_pc !== 32'h4180) begin
            errors++;
            $display("FAIL exc_dropped: got v=%b pc=%h, required 0/4180", dn_valid, dn_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        pc = 32'h5000;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, pc);
            dn_ready = ($urandom % 3) != 0;
            flush    = ($urandom % 40) == 0;
            req      = ($urandom % 60) == 0;
            tick();
            pc = pc + 32'h4;
        end
        flush = 1'b0; req = 1'b0;
        drive(1'b0, 32'h0);
        dn_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d entries left, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        dn_ready = 1'b0;
        drive(1'b1, 32'h3030); tick();
        drive(1'b1, 32'h3034); tick();
        drive(1'b0, 32'h0);
        reset = 1'b0;
        #1;
        checks++;
        if (dn_valid !== 1'b0 || dn_pc !== 32'h3000 || dn_instr !== 32'h0 || occupancy !== 2'd0 || up_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got v=%b pc=%h instr=%h occ=%0d rdy=%b, required 0/3000/0/0/1",
                     dn_valid, dn_pc, dn_instr, occupancy, up_ready);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        dn_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush_full();
        test_exception();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
